mem_sys: RTL and testbench

- Parametrised successor to the single-CPU memory/MMIO block: program RAM, tile-map and frame-buffer regions, display pixel pipeline, scroll/scale registers, PS/2 read register.
- Adds buffered UART TX/RX FIFOs with a valid/ready byte interface, a status register with sticky error bits, configurable tile size and region bases, and reset of all control state.
- Sits between CPU (two read ports, one write port), VGA timing, PS/2 and UART PHY blocks.

---
 rtl/mem_sys.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_sys.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sys.sv
// mem_sys: CPU memory/MMIO hub: RAM, tile-map/frame-buffer display path, scroll/scale, PS/2, buffered UART.
// Optional macro UART_LOOPBACK_EN adds CTRL[0] internal TX->RX loopback.

// Single-clock FIFO holding one UART byte stream.
// Latency: a pushed byte reaches the head on the following cycle.
// Backpressure: push accepted if not full or popping this cycle; pop ignored when empty.
module mem_sys_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [W-1:0]            din,
  input  logic                    pop,
  output logic [W-1:0]            dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  buf_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = buf_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// Memory/MMIO top level between CPU, VGA timing, PS/2 and UART PHY.
// Latency: CPU reads and pixel lookup both 2 cycles after the sampling edge.
// Backpressure: UART TX valid/ready; full FIFOs drop new bytes and set sticky status bits.
module mem_sys #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] TILEMAP_BASE = 'hC000,
  parameter logic [ADDR_W-1:0] FB_BASE      = 'hE000,
  parameter logic [ADDR_W-1:0] IO_BASE      = 'hF000,
  parameter int                TILE_LOG2    = 3,
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ps2_ren,
  input  logic [15:0]       ps2_data_in,
  input  logic [9:0]        pixel_x_in,
  input  logic [9:0]        pixel_y_in,
  output logic [11:0]       pixel,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid
);
  localparam int T  = TILE_LOG2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] A_TX   = IO_BASE;
  localparam logic [ADDR_W-1:0] A_RX   = IO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_ST   = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL = IO_BASE + ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_PS2  = '1;
  localparam logic [ADDR_W-1:0] A_VS   = A_PS2 - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_HS   = A_PS2 - ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SC   = A_PS2 - ADDR_W'(3);

  logic [DATA_W-1:0] mem [0:IO_BASE-1];
  logic [DATA_W-1:0] scale, hscroll, vscroll, status, ctrl_rd;
  logic              tx_overflow, rx_overrun;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]        tx_dout, rx_dout, rx_din;
  logic [CW-1:0]     rx_count;

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return (a < IO_BASE) ? mem[a] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] io_rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a == A_RX)        v = rx_empty ? '0 : DATA_W'(rx_dout);
    else if (a == A_ST)   v = status;
    else if (a == A_CTRL) v = ctrl_rd;
    else if (a == A_SC)   v = scale;
    else if (a == A_HS)   v = hscroll;
    else if (a == A_VS)   v = vscroll;
    else if (a == A_PS2)  v = DATA_W'(ps2_data_in);
    return v;
  endfunction

  assign status = DATA_W'({8'(rx_count), 2'b00, rx_overrun, tx_overflow,
                           rx_empty, rx_full, tx_empty, tx_full});

  always_ff @(posedge clk) begin
    if (wen && waddr < IO_BASE) mem[waddr] <= wdata;
  end

  // Memory is read at the sampling edge so a same-edge write returns old data;
  // IO is resolved one edge later, which is also when RX pops and ps2_ren fire.
  logic [ADDR_W-1:0] a0_q, a1_q;
  logic              ren_q;
  logic [DATA_W-1:0] m0_q, m1_q, d0_q, d1_q;

  assign rx_pop = ren_q && (a1_q == A_RX) && !rx_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0; a1_q <= '0; ren_q <= 1'b0;
      m0_q <= '0; m1_q <= '0; d0_q <= '0; d1_q <= '0;
      rdata0 <= '0; rdata1 <= '0; ps2_ren <= 1'b0;
    end else begin
      a0_q    <= raddr0;
      a1_q    <= raddr1;
      ren_q   <= ren;
      m0_q    <= mem_rd(raddr0);
      m1_q    <= mem_rd(raddr1);
      d0_q    <= (a0_q >= IO_BASE) ? io_rd(a0_q) : m0_q;
      d1_q    <= (a1_q >= IO_BASE) ? io_rd(a1_q) : m1_q;
      rdata0  <= d0_q;
      rdata1  <= d1_q;
      ps2_ren <= ren_q && (a1_q == A_PS2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale <= '0; hscroll <= '0; vscroll <= '0;
      tx_overflow <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      if (wen && waddr == A_SC) scale   <= wdata;
      if (wen && waddr == A_HS) hscroll <= wdata;
      if (wen && waddr == A_VS) vscroll <= wdata;
      if (tx_push && tx_full && !tx_pop)     tx_overflow <= 1'b1;
      else if (wen && waddr == A_ST)         tx_overflow <= 1'b0;
      if (rx_push && rx_full && !rx_pop)     rx_overrun  <= 1'b1;
      else if (wen && waddr == A_ST)         rx_overrun  <= 1'b0;
    end
  end

  assign tx_push      = wen && (waddr == A_TX);
  assign uart_tx_data = tx_dout;

`ifdef UART_LOOPBACK_EN
  logic ctrl_lb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ctrl_lb <= 1'b0;
    else if (wen && waddr == A_CTRL)  ctrl_lb <= wdata[0];
  end
  assign ctrl_rd       = DATA_W'(ctrl_lb);
  assign uart_tx_valid = !tx_empty && !ctrl_lb;
  assign tx_pop        = ctrl_lb ? (!tx_empty && !rx_full) : (uart_tx_valid && uart_tx_ready);
  assign rx_push       = ctrl_lb ? tx_pop  : uart_rx_valid;
  assign rx_din        = ctrl_lb ? tx_dout : uart_rx_data;
`else
  assign ctrl_rd       = '0;
  assign uart_tx_valid = !tx_empty;
  assign tx_pop        = uart_tx_valid && uart_tx_ready;
  assign rx_push       = uart_rx_valid;
  assign rx_din        = uart_rx_data;
`endif

  mem_sys_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(wdata[7:0]), .pop(tx_pop),
    .dout(tx_dout), .count(), .full(tx_full), .empty(tx_empty)
  );

  mem_sys_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_din), .pop(rx_pop),
    .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  // Display: scroll/scale, then frame-buffer tile lookup, then tile-map texel.
  logic [9:0]          px_q, py_q;
  logic [DATA_W-1:0]   fb_q, tm_word;
  logic [T-1:0]        pxm_q, pym_q;
  logic                odd_q;
  logic [19-2*T:0]     fidx;
  logic [7:0]          tile;
  logic [ADDR_W-1:0]   fb_addr, tm_addr;

  // Tiles per row is a power of two, so the frame index is a concatenation.
  assign fidx    = {py_q[9:T], px_q[9:T]};
  assign fb_addr = FB_BASE + ADDR_W'(fidx >> 1);
  assign tile    = odd_q ? fb_q[15:8] : fb_q[7:0];
  assign tm_addr = TILEMAP_BASE + ADDR_W'({tile, pym_q, pxm_q});
  assign tm_word = mem_rd(tm_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0; py_q <= '0; fb_q <= '0;
      pxm_q <= '0; pym_q <= '0; odd_q <= 1'b0; pixel <= '0;
    end else begin
      px_q  <= (pixel_x_in >> scale[1:0]) - hscroll[9:0];
      py_q  <= (pixel_y_in >> scale[1:0]) - vscroll[9:0];
      fb_q  <= mem_rd(fb_addr);
      pxm_q <= px_q[T-1:0];
      pym_q <= py_q[T-1:0];
      odd_q <= fidx[0];
      pixel <= tm_word[11:0];
    end
  end
endmodule

// File: tb/tb_mem_sys.sv
// Self-checking bench for mem_sys: scoreboard queues hold expected read data, TX bytes and pixels.
module tb_mem_sys;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] raddr0 = '0, raddr1 = '0, waddr = '0, wdata = '0;
  logic [15:0] rdata0, rdata1;
  logic        ren = 1'b0, wen = 1'b0;
  logic        ps2_ren;
  logic [15:0] ps2_data_in = '0;
  logic [9:0]  pixel_x_in = '0, pixel_y_in = '0;
  logic [11:0] pixel;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;

  localparam logic [15:0] A_TX = 16'hF000, A_RX = 16'hF001, A_ST = 16'hF002, A_CTRL = 16'hF003;
  localparam logic [15:0] A_SC = 16'hFFFC, A_HS = 16'hFFFD, A_VS = 16'hFFFE, A_PS2 = 16'hFFFF;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [11:0] pix_q[$];

  mem_sys dut (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rdata0), .ren(ren), .raddr1(raddr1),
    .rdata1(rdata1), .wen(wen), .waddr(waddr), .wdata(wdata), .ps2_ren(ps2_ren),
    .ps2_data_in(ps2_data_in), .pixel_x_in(pixel_x_in), .pixel_y_in(pixel_y_in),
    .pixel(pixel), .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // All drivers start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd1(input logic [15:0] a, output logic [15:0] d);
    raddr1 = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    tick();
    tick();
    d = rdata1;
  endtask

  task automatic test_reset();
    #12;
    n_tests += 5;
    if (rdata0 !== 16'h0)     begin n_fail++; $display("FAIL reset_rdata0: got %h want 0000", rdata0); end
    if (rdata1 !== 16'h0)     begin n_fail++; $display("FAIL reset_rdata1: got %h want 0000", rdata1); end
    if (pixel !== 12'h0)      begin n_fail++; $display("FAIL reset_pixel: got %h want 000", pixel); end
    if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
    if (ps2_ren !== 1'b0)     begin n_fail++; $display("FAIL reset_ps2_ren: got %b want 0", ps2_ren); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_ram();
    logic [15:0] got, e;
    raddr0 = 16'h0011;
    wr(16'h0011, 16'hAAAA);
    wr(16'h0010, 16'h1234);
    raddr0 = 16'h0010; raddr1 = 16'h0010; ren = 1'b1;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    tick();
    ren = 1'b0;
    tick();
    n_tests++;
    if (rdata0 !== 16'hAAAA) begin n_fail++; $display("FAIL ram_latency_early: got %h want aaaa", rdata0); end
    tick();
    e = exp_q.pop_front(); n_tests++;
    if (rdata0 !== e) begin n_fail++; $display("FAIL ram_port0: got %h want %h", rdata0, e); end
    e = exp_q.pop_front(); n_tests++;
    if (rdata1 !== e) begin n_fail++; $display("FAIL ram_port1: got %h want %h", rdata1, e); end
    // Same-edge write and read of one address.
    wen = 1'b1; waddr = 16'h0010; wdata = 16'h5678; raddr1 = 16'h0010; ren = 1'b1;
    exp_q.push_back(16'h1234);
    tick();
    wen = 1'b0; ren = 1'b0;
    tick(); tick();
    e = exp_q.pop_front(); n_tests++;
    if (rdata1 !== e) begin n_fail++; $display("FAIL ram_rw_same_cycle: got %h want %h", rdata1, e); end
    exp_q.push_back(16'h5678);
    rd1(16'h0010, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL ram_after_write: got %h want %h", got, e); end
  endtask

  task automatic test_tx();
    logic [15:0] got, e;
    int drained;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'(i));
      wr(A_TX, 16'(i));
    end
    n_tests += 2;
    if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_full: got %b want 1", uart_tx_valid); end
    if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL tx_head: got %h want 00", uart_tx_data); end
    exp_q.push_back(16'h0019);
    rd1(A_ST, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL tx_status_full: got %h want %h", got, e); end
    uart_tx_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (uart_tx_valid) begin
        n_tests++;
        if (tx_q.size() == 0) begin
          n_fail++; $display("FAIL tx_extra_byte: got %h want none", uart_tx_data);
        end else begin
          e = 16'(tx_q.pop_front());
          if (16'(uart_tx_data) !== e) begin n_fail++; $display("FAIL tx_drain: got %h want %h", uart_tx_data, e[7:0]); end
        end
        drained++;
      end
      tick();
      if (tx_q.size() == 0 && !uart_tx_valid) break;
    end
    uart_tx_ready = 1'b0;
    n_tests++;
    if (drained != 16) begin n_fail++; $display("FAIL tx_drain_count: got %0d want 16", drained); end
    wr(A_ST, 16'h0000);
    exp_q.push_back(16'h000A);
    rd1(A_ST, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL tx_status_cleared: got %h want %h", got, e); end
  endtask

  task automatic test_rx();
    logic [15:0] got, e;
    uart_rx_valid = 1'b1; uart_rx_data = 8'hA5; tick();
    uart_rx_data = 8'h3C; tick();
    uart_rx_valid = 1'b0;
    exp_q.push_back(16'h0202);
    rd1(A_ST, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL rx_status_two: got %h want %h", got, e); end
    exp_q.push_back(16'h00A5); exp_q.push_back(16'h003C); exp_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      rd1(A_RX, got);
      e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin n_fail++; $display("FAIL rx_pop%0d: got %h want %h", i, got, e); end
    end
    exp_q.push_back(16'h000A);
    rd1(A_ST, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL rx_status_empty: got %h want %h", got, e); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] got, e;
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      uart_rx_data = 8'(16 + i);
      if (i < 16) exp_q.push_back(16'(16 + i));
      tick();
    end
    uart_rx_valid = 1'b0;
    rd1(A_ST, got); n_tests++;
    if (got !== 16'h1026) begin n_fail++; $display("FAIL rx_status_overrun: got %h want 1026", got); end
    rd1(A_RX, got);
    e = exp_q.pop_front(); n_tests++;
    if (got !== e) begin n_fail++; $display("FAIL rx_head_after_overrun: got %h want %h", got, e); end
    rd1(A_ST, got); n_tests++;
    if (got !== 16'h0F22) begin n_fail++; $display("FAIL rx_status_after_pop: got %h want 0f22", got); end
    wr(A_ST, 16'hFFFF);
    rd1(A_ST, got); n_tests++;
    if (got !== 16'h0F02) begin n_fail++; $display("FAIL rx_sticky_clear: got %h want 0f02", got); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TX, 16'(8'h40 + i));
    n_tests++;
    if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_tx_valid_before: got %b want 1", uart_tx_valid); end
    rst = 1'b1;
    #1;
    n_tests++;
    if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tx_valid_async: got %b want 0", uart_tx_valid); end
    @(posedge clk); #1 rst = 1'b0;
    rd1(A_ST, got); n_tests++;
    if (got !== 16'h000A) begin n_fail++; $display("FAIL mid_status: got %h want 000a", got); end
  endtask

  task automatic test_ps2();
    logic [15:0] got;
    ps2_data_in = 16'hBEEF;
    raddr0 = A_PS2; raddr1 = 16'h0010; ren = 1'b0;
    tick(); tick();
    n_tests++;
    if (ps2_ren !== 1'b0) begin n_fail++; $display("FAIL ps2_port0_side_effect: got %b want 0", ps2_ren); end
    tick();
    n_tests++;
    if (rdata0 !== 16'hBEEF) begin n_fail++; $display("FAIL ps2_port0_data: got %h want beef", rdata0); end
    raddr0 = 16'h0010; raddr1 = A_PS2; ren = 1'b1;
    tick();
    ren = 1'b0;
    n_tests++;
    if (ps2_ren !== 1'b0) begin n_fail++; $display("FAIL ps2_ren_early: got %b want 0", ps2_ren); end
    tick();
    n_tests++;
    if (ps2_ren !== 1'b1) begin n_fail++; $display("FAIL ps2_ren_pulse: got %b want 1", ps2_ren); end
    tick();
    got = rdata1;
    n_tests += 2;
    if (ps2_ren !== 1'b0) begin n_fail++; $display("FAIL ps2_ren_width: got %b want 0", ps2_ren); end
    if (got !== 16'hBEEF) begin n_fail++; $display("FAIL ps2_port1_data: got %h want beef", got); end
  endtask

  task automatic test_display();
    logic [15:0] sc [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0};
    logic [15:0] hs [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0};
    logic [15:0] vs [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd8};
    logic [9:0]  xs [7] = '{10'd0, 10'd1, 10'd8, 10'd0, 10'd16, 10'd1, 10'd0};
    logic [9:0]  ys [7] = '{10'd0, 10'd0, 10'd0, 10'd8, 10'd0, 10'd0, 10'd16};
    logic [11:0] ex [7] = '{12'hF00, 12'h123, 12'h777, 12'h456, 12'h777, 12'hF00, 12'h456};
    logic [11:0] e;
    wr(16'hE000, 16'h0502);
    wr(16'hE040, 16'h0003);
    wr(16'hC080, 16'h0F00);
    wr(16'hC081, 16'h0123);
    wr(16'hC140, 16'h0777);
    wr(16'hC0C0, 16'h0456);
    for (int i = 0; i < 7; i++) begin
      wr(A_SC, sc[i]); wr(A_HS, hs[i]); wr(A_VS, vs[i]);
      pixel_x_in = xs[i]; pixel_y_in = ys[i];
      pix_q.push_back(ex[i]);
      tick(); tick(); tick();
      e = pix_q.pop_front(); n_tests++;
      if (pixel !== e) begin n_fail++; $display("FAIL pixel%0d: got %h want %h", i, pixel, e); end
    end
    pixel_x_in = '0; pixel_y_in = '0;
  endtask

  task automatic test_ctrl();
    logic [15:0] got;
`ifdef UART_LOOPBACK_EN
    int seen;
    wr(A_CTRL, 16'h0001);
    rd1(A_CTRL, got); n_tests++;
    if (got !== 16'h0001) begin n_fail++; $display("FAIL lb_ctrl_read: got %h want 0001", got); end
    uart_tx_ready = 1'b1;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    wr(A_TX, 16'h0055);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (uart_tx_valid !== 1'b0) seen++;
      tick();
    end
    uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL lb_tx_valid: got %0d cycles high want 0", seen); end
    exp_q.push_back(16'h0055); exp_q.push_back(16'h0000);
    for (int i = 0; i < 2; i++) begin
      rd1(A_RX, got); n_tests++;
      if (got !== exp_q[0]) begin n_fail++; $display("FAIL lb_rx%0d: got %h want %h", i, got, exp_q[0]); end
      void'(exp_q.pop_front());
    end
`else
    wr(A_CTRL, 16'h0001);
    rd1(A_CTRL, got); n_tests++;
    if (got !== 16'h0000) begin n_fail++; $display("FAIL ctrl_no_storage: got %h want 0000", got); end
`endif
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_rx();
    test_rx_overrun();
    test_reset_mid();
    test_ps2();
    test_display();
    test_ctrl();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
